// File: rtl/i2c_reg_pkg.sv
// -----------------------------------------------------------------------------
// i2c_reg_pkg
// Shared constants and types for the I2C register bank: register count,
// writable/read-only address split, address constants, FSM state encoding
// and the register-pointer advance helper.
// No ports (package).
// -----------------------------------------------------------------------------
package i2c_reg_pkg;

   localparam int REG_COUNT = 16;
   localparam int PTR_W     = $clog2(REG_COUNT);

   typedef logic [PTR_W-1:0] ptr_t;

   // Registers 0x0..RW_LIMIT are writable; STATUS_BASE..0xF mirror status_in.
   localparam ptr_t RW_LIMIT    = 4'hB;
   localparam ptr_t STATUS_BASE = 4'hC;
   localparam ptr_t ADDR_FIRST  = 4'h0;
   localparam ptr_t ADDR_LAST   = 4'hF;
   localparam int   RW_COUNT    = int'(RW_LIMIT) + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_PTR = 2'b01,
      DATA     = 2'b10
   } state_t;

   // Pointer advance with explicit wrap from the last address to the first.
   function automatic ptr_t ptr_next(input ptr_t p);
      ptr_t n;
      if (p == ADDR_LAST) begin
         n = ADDR_FIRST;
      end else begin
         n = p + 4'h1;
      end
      return n;
   endfunction

endpackage

// File: rtl/i2c_reg_bank_if.sv
// -----------------------------------------------------------------------------
// i2c_reg_bank_if
// Byte-level handshake between i2c_slave and the register bank.
//   slave_asserted     : addressed-transaction level
//   slave_in_tx_mode   : 1 = master read
//   slave_rx_buffer    : received byte, bit 0 = MSB (first on the wire)
//   slave_rx_available : level, rising edge = new byte
//   slave_tx_request   : level, rising edge = next byte wanted
//   slave_tx_buffer    : byte to transmit, bit 0 = MSB
// modport master : i2c_slave side;  modport slave : register bank side.
// -----------------------------------------------------------------------------
interface i2c_reg_bank_if;
   logic       slave_asserted;
   logic       slave_in_tx_mode;
   logic [0:7] slave_rx_buffer;
   logic       slave_rx_available;
   logic       slave_tx_request;
   logic [0:7] slave_tx_buffer;

   modport master (
      output slave_asserted,
      output slave_in_tx_mode,
      output slave_rx_buffer,
      output slave_rx_available,
      output slave_tx_request,
      input  slave_tx_buffer
   );

   modport slave (
      input  slave_asserted,
      input  slave_in_tx_mode,
      input  slave_rx_buffer,
      input  slave_rx_available,
      input  slave_tx_request,
      output slave_tx_buffer
   );
endinterface

// File: rtl/i2c_edge_det.sv
// -----------------------------------------------------------------------------
// i2c_edge_det
// Two-flop rising-edge detector. The input is registered once and the edge is
// taken between the two registered copies, giving a clean 1-cycle event.
//   clk     : clock
//   reset_n : asynchronous active-low reset (both flops cleared)
//   din     : level input
//   rise    : 1-cycle pulse after a 0->1 transition of din
// -----------------------------------------------------------------------------
module i2c_edge_det (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise
);

   logic q1_r;
   logic q2_r;

   // Two-stage shift of the input level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q1_r <= 1'b0;
         q2_r <= 1'b0;
      end else begin
         q1_r <= din;
         q2_r <= q1_r;
      end
   end

   assign rise = q1_r & ~q2_r;

endmodule

// File: rtl/i2c_reg_bank.sv
// -----------------------------------------------------------------------------
// i2c_reg_bank
// Register bank behind an I2C slave: the first written byte of a transaction
// sets the register pointer, following written bytes land in registers
// 0x0-0xB, reads return registers 0x0-0xB or status_in for 0xC-0xF.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus           : i2c_reg_bank_if.slave byte handshake from i2c_slave
//   ctrl_regs     : registers 0x0-0xB, register k at [8k+7:8k]
//   status_in     : read-only registers 0xC-0xF, 0xC+j at [8j+7:8j]
//   reg_wr_strobe : 1-cycle pulse per accepted write
//   reg_wr_addr   : address of the write flagged by reg_wr_strobe
// Build option: I2C_REG_BANK_AUTOINC_EN -- when defined the pointer advances
// after every data byte; when undefined it stays at the loaded address.
// -----------------------------------------------------------------------------
module i2c_reg_bank
   import i2c_reg_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   i2c_reg_bank_if.slave bus,
   output logic [95:0]   ctrl_regs,
   input  logic [31:0]   status_in,
   output logic          reg_wr_strobe,
   output logic [3:0]    reg_wr_addr
);

   logic       asserted_rise_s;
   logic       rx_rise_s;
   logic       tx_rise_s;
   logic       start_s;
   logic       armed_r;
   state_t     state_r;
   state_t     next_state_s;
   logic       ptr_load_s;
   logic       wr_evt_s;
   logic       tx_evt_s;
   ptr_t       ptr_r;
   ptr_t       ptr_adv_s;
   logic [7:0] rd_byte_s;
   logic [7:0] regs_r [0:RW_COUNT-1];
   logic [0:7] tx_buffer_r;

   i2c_edge_det u_asserted_det (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (bus.slave_asserted),
      .rise    (asserted_rise_s)
   );

   i2c_edge_det u_rx_det (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (bus.slave_rx_available),
      .rise    (rx_rise_s)
   );

   i2c_edge_det u_tx_det (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (bus.slave_tx_request),
      .rise    (tx_rise_s)
   );

   // Arms transaction start once slave_asserted has been seen low, so a level
   // still high across a reset is not mistaken for a fresh transaction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_r <= 1'b0;
      end else if (!bus.slave_asserted) begin
         armed_r <= 1'b1;
      end else begin
         armed_r <= armed_r;
      end
   end

   assign start_s = asserted_rise_s & armed_r;

`ifdef I2C_REG_BANK_AUTOINC_EN
   assign ptr_adv_s = ptr_next(ptr_r);
`else
   assign ptr_adv_s = ptr_r;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state and datapath controls. tx events only count in read mode
   // because i2c_slave also raises tx_request on the write-address ACK.
   always_comb begin
      next_state_s = state_r;
      ptr_load_s   = 1'b0;
      wr_evt_s     = 1'b0;
      tx_evt_s     = 1'b0;
      if (!bus.slave_asserted) begin
         next_state_s = IDLE;
      end else if (start_s) begin
         next_state_s = WAIT_PTR;
      end else begin
         case (state_r)
            IDLE: begin
               next_state_s = IDLE;
            end
            WAIT_PTR: begin
               if (rx_rise_s && !bus.slave_in_tx_mode) begin
                  ptr_load_s   = 1'b1;
                  next_state_s = DATA;
               end else if (tx_rise_s && bus.slave_in_tx_mode) begin
                  tx_evt_s     = 1'b1;
                  next_state_s = DATA;
               end else begin
                  next_state_s = WAIT_PTR;
               end
            end
            DATA: begin
               next_state_s = DATA;
               if (rx_rise_s && !bus.slave_in_tx_mode) begin
                  wr_evt_s = 1'b1;
               end else if (tx_rise_s && bus.slave_in_tx_mode) begin
                  tx_evt_s = 1'b1;
               end else begin
                  wr_evt_s = 1'b0;
               end
            end
            default: begin
               next_state_s = IDLE;
            end
         endcase
      end
   end

   // Read mux: writable registers below STATUS_BASE, live status_in above.
   always_comb begin
      rd_byte_s = 8'h00;
      if (ptr_r >= STATUS_BASE) begin
         rd_byte_s = status_in[{ptr_r[1:0], 3'b000} +: 8];
      end else begin
         rd_byte_s = regs_r[ptr_r];
      end
   end

   // Pointer, register file, transmit byte and write strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r         <= ADDR_FIRST;
         tx_buffer_r   <= 8'h00;
         reg_wr_strobe <= 1'b0;
         reg_wr_addr   <= 4'h0;
         for (int k = 0; k < RW_COUNT; k++) begin
            regs_r[k] <= 8'h00;
         end
      end else begin
         reg_wr_strobe <= 1'b0;
         if (ptr_load_s) begin
            // Only the low nibble addresses the 16-entry map.
            ptr_r <= bus.slave_rx_buffer[4:7];
         end else if (wr_evt_s) begin
            if (ptr_r <= RW_LIMIT) begin
               regs_r[ptr_r] <= bus.slave_rx_buffer;
               reg_wr_strobe <= 1'b1;
               reg_wr_addr   <= ptr_r;
            end
            ptr_r <= ptr_adv_s;
         end else if (tx_evt_s) begin
            tx_buffer_r <= rd_byte_s;
            ptr_r       <= ptr_adv_s;
         end
      end
   end

   // Flatten the register file onto the ctrl_regs bus.
   always_comb begin
      ctrl_regs = {96{1'b0}};
      for (int k = 0; k < RW_COUNT; k++) begin
         ctrl_regs[8*k +: 8] = regs_r[k];
      end
   end

   assign bus.slave_tx_buffer = tx_buffer_r;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_bank
// Table-driven bench for i2c_reg_bank: each record is one bus operation plus
// the hand-computed strobe, write address, tx byte and pointer after it.
// Expected values depend on I2C_REG_BANK_AUTOINC_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_reg_bank;
   import i2c_reg_pkg::*;

`ifdef I2C_REG_BANK_AUTOINC_EN
   localparam bit AI = 1'b1;
`else
   localparam bit AI = 1'b0;
`endif

   typedef enum logic [1:0] {OP_START, OP_STOP, OP_RX, OP_TX} op_t;

   typedef struct {
      op_t        op;
      logic [7:0] data;
      logic       exp_strobe;
      logic [3:0] exp_waddr;
      logic [7:0] exp_tx;
      logic [3:0] exp_ptr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [95:0] ctrl_regs;
   logic [31:0] status_in;
   logic        reg_wr_strobe;
   logic [3:0]  reg_wr_addr;

   i2c_reg_bank_if bus ();

   i2c_reg_bank dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .ctrl_regs     (ctrl_regs),
      .status_in     (status_in),
      .reg_wr_strobe (reg_wr_strobe),
      .reg_wr_addr   (reg_wr_addr)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          strobe_cnt = 0;
   logic        cap_strobe;
   logic [3:0]  cap_waddr;
   logic [95:0] exp_ctrl;
   vec_t        vecs [28];

   always @(negedge clk) begin
      if (reg_wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input op_t op, input logic [7:0] d, input logic s,
                               input logic [3:0] w, input logic [7:0] tx, input logic [3:0] p);
      vec_t v;
      v.op = op; v.data = d; v.exp_strobe = s; v.exp_waddr = w; v.exp_tx = tx; v.exp_ptr = p;
      return v;
   endfunction

   // One bus operation; strobe is captured in the cycle a write strobe is due.
   task automatic do_op(input op_t op, input logic [7:0] data);
      cap_strobe = 1'b0;
      cap_waddr  = 4'h0;
      @(posedge clk); #1;
      case (op)
         OP_START: begin
            bus.slave_asserted   = 1'b0;
            bus.slave_in_tx_mode = data[0];
            repeat (2) @(posedge clk);
            #1 bus.slave_asserted = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            cap_strobe = reg_wr_strobe;
         end
         OP_STOP: begin
            bus.slave_asserted = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            cap_strobe = reg_wr_strobe;
         end
         OP_RX: begin
            bus.slave_rx_buffer    = data;
            bus.slave_rx_available = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            cap_strobe = reg_wr_strobe;
            cap_waddr  = reg_wr_addr;
            @(posedge clk); #1 bus.slave_rx_available = 1'b0;
         end
         default: begin
            bus.slave_tx_request = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            cap_strobe = reg_wr_strobe;
            @(posedge clk); #1 bus.slave_tx_request = 1'b0;
         end
      endcase
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
   endtask

   initial begin
      int c0;
      reset_n                = 1'b0;
      bus.slave_asserted     = 1'b0;
      bus.slave_in_tx_mode   = 1'b0;
      bus.slave_rx_buffer    = 8'h00;
      bus.slave_rx_available = 1'b0;
      bus.slave_tx_request   = 1'b0;
      status_in              = 32'h7E5A_3C11;
      exp_ctrl               = {96{1'b0}};

      // Write burst, restart read, ignored rx in read, write-ACK tx, RO write,
      // reg0 write, 0xB boundary, wrap through 0xF.
      vecs[0]  = mk(OP_START, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0);
      vecs[1]  = mk(OP_RX,    8'h03, 1'b0, 4'h0, 8'h00, 4'h3);
      vecs[2]  = mk(OP_RX,    8'hAA, 1'b1, 4'h3, 8'h00, AI ? 4'h4 : 4'h3);
      vecs[3]  = mk(OP_RX,    8'hBB, 1'b1, AI ? 4'h4 : 4'h3, 8'h00, AI ? 4'h5 : 4'h3);
      vecs[4]  = mk(OP_START, 8'h00, 1'b0, 4'h0, 8'h00, AI ? 4'h5 : 4'h3);
      vecs[5]  = mk(OP_RX,    8'h03, 1'b0, 4'h0, 8'h00, 4'h3);
      vecs[6]  = mk(OP_START, 8'h01, 1'b0, 4'h0, 8'h00, 4'h3);
      vecs[7]  = mk(OP_TX,    8'h00, 1'b0, 4'h0, AI ? 8'hAA : 8'hBB, AI ? 4'h4 : 4'h3);
      vecs[8]  = mk(OP_TX,    8'h00, 1'b0, 4'h0, 8'hBB, AI ? 4'h5 : 4'h3);
      vecs[9]  = mk(OP_RX,    8'h99, 1'b0, 4'h0, 8'hBB, AI ? 4'h5 : 4'h3);
      vecs[10] = mk(OP_STOP,  8'h00, 1'b0, 4'h0, 8'hBB, AI ? 4'h5 : 4'h3);
      vecs[11] = mk(OP_START, 8'h00, 1'b0, 4'h0, 8'hBB, AI ? 4'h5 : 4'h3);
      vecs[12] = mk(OP_TX,    8'h00, 1'b0, 4'h0, 8'hBB, AI ? 4'h5 : 4'h3);
      vecs[13] = mk(OP_RX,    8'hAD, 1'b0, 4'h0, 8'hBB, 4'hD);
      vecs[14] = mk(OP_RX,    8'h55, 1'b0, 4'h0, 8'hBB, AI ? 4'hE : 4'hD);
      vecs[15] = mk(OP_START, 8'h00, 1'b0, 4'h0, 8'hBB, AI ? 4'hE : 4'hD);
      vecs[16] = mk(OP_RX,    8'h00, 1'b0, 4'h0, 8'hBB, 4'h0);
      vecs[17] = mk(OP_RX,    8'h5C, 1'b1, 4'h0, 8'hBB, AI ? 4'h1 : 4'h0);
      vecs[18] = mk(OP_START, 8'h00, 1'b0, 4'h0, 8'hBB, AI ? 4'h1 : 4'h0);
      vecs[19] = mk(OP_RX,    8'h0B, 1'b0, 4'h0, 8'hBB, 4'hB);
      vecs[20] = mk(OP_RX,    8'h11, 1'b1, 4'hB, 8'hBB, AI ? 4'hC : 4'hB);
      vecs[21] = mk(OP_RX,    8'h22, AI ? 1'b0 : 1'b1, 4'hB, 8'hBB, AI ? 4'hD : 4'hB);
      vecs[22] = mk(OP_START, 8'h00, 1'b0, 4'h0, 8'hBB, AI ? 4'hD : 4'hB);
      vecs[23] = mk(OP_RX,    8'hAF, 1'b0, 4'h0, 8'hBB, 4'hF);
      vecs[24] = mk(OP_START, 8'h01, 1'b0, 4'h0, 8'hBB, 4'hF);
      vecs[25] = mk(OP_TX,    8'h00, 1'b0, 4'h0, 8'h7E, AI ? 4'h0 : 4'hF);
      vecs[26] = mk(OP_TX,    8'h00, 1'b0, 4'h0, AI ? 8'h5C : 8'h7E, AI ? 4'h1 : 4'hF);
      vecs[27] = mk(OP_STOP,  8'h00, 1'b0, 4'h0, AI ? 8'h5C : 8'h7E, AI ? 4'h1 : 4'hF);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset ctrl_regs", ctrl_regs, 96'h0);
      check("reset tx_buffer", 96'(bus.slave_tx_buffer), 96'h0);
      check("reset strobe", 96'(reg_wr_strobe), 96'h0);
      check("reset waddr", 96'(reg_wr_addr), 96'h0);
      check("reset ptr", 96'(dut.ptr_r), 96'h0);
      check("reset state", 96'(dut.state_r), 96'(IDLE));
      @(posedge clk); #1 reset_n = 1'b1;

      for (int i = 0; i < 28; i++) begin
         c0 = strobe_cnt;
         do_op(vecs[i].op, vecs[i].data);
         check($sformatf("v%0d strobe", i), 96'(cap_strobe), 96'(vecs[i].exp_strobe));
         check($sformatf("v%0d strobe_count", i), 96'(strobe_cnt - c0), 96'(vecs[i].exp_strobe));
         if (vecs[i].exp_strobe) begin
            check($sformatf("v%0d waddr", i), 96'(cap_waddr), 96'(vecs[i].exp_waddr));
            exp_ctrl[{vecs[i].exp_waddr, 3'b000} +: 8] = vecs[i].data;
         end
         check($sformatf("v%0d tx_buffer", i), 96'(bus.slave_tx_buffer), 96'(vecs[i].exp_tx));
         check($sformatf("v%0d ptr", i), 96'(dut.ptr_r), 96'(vecs[i].exp_ptr));
         check($sformatf("v%0d ctrl_regs", i), ctrl_regs, exp_ctrl);
      end

      // Reset in the middle of a write, with slave_asserted still high.
      do_op(OP_START, 8'h00);
      do_op(OP_RX, 8'h05);
      check("pre-reset ptr", 96'(dut.ptr_r), 96'h5);
      @(posedge clk); #1 reset_n = 1'b0;
      @(negedge clk);
      exp_ctrl = {96{1'b0}};
      check("midreset ctrl_regs", ctrl_regs, exp_ctrl);
      check("midreset tx_buffer", 96'(bus.slave_tx_buffer), 96'h0);
      check("midreset strobe", 96'(reg_wr_strobe), 96'h0);
      check("midreset waddr", 96'(reg_wr_addr), 96'h0);
      check("midreset ptr", 96'(dut.ptr_r), 96'h0);
      check("midreset state", 96'(dut.state_r), 96'(IDLE));
      @(posedge clk); #1 reset_n = 1'b1;

      c0 = strobe_cnt;
      do_op(OP_RX, 8'h07);
      do_op(OP_RX, 8'h66);
      check("postreset strobe_count", 96'(strobe_cnt - c0), 96'h0);
      check("postreset ptr", 96'(dut.ptr_r), 96'h0);
      check("postreset ctrl_regs", ctrl_regs, exp_ctrl);
      check("postreset state", 96'(dut.state_r), 96'(IDLE));

      // A fresh transaction works again.
      do_op(OP_STOP, 8'h00);
      do_op(OP_START, 8'h00);
      do_op(OP_RX, 8'h02);
      do_op(OP_RX, 8'h77);
      check("fresh strobe", 96'(cap_strobe), 96'h1);
      check("fresh waddr", 96'(cap_waddr), 96'h2);
      exp_ctrl[23:16] = 8'h77;
      check("fresh ctrl_regs", ctrl_regs, exp_ctrl);
      check("fresh ptr", 96'(dut.ptr_r), AI ? 96'h3 : 96'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
